// File: rtl/lfsr_param.sv
// Parametrised LFSR pseudo-random generator with Galois/Fibonacci modes, seed load,
// all-zero lock-up guard and period-wrap detection with a step counter.
module lfsr_param #(
    parameter int              WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b00100,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             zfix
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             zfix_q, zfix_d;

    logic [WIDTH-1:0] galois_ns;
    logic [WIDTH-1:0] fib_ns;
    logic             fib_fb;
    logic [WIDTH-1:0] ns;
    logic             seed_zero;
    logic [WIDTH-1:0] load_val;

    // Both feedback structures are computed every cycle; mode only selects which one steps.
    always_comb begin
        galois_ns    = '0;
        galois_ns[0] = q_q[WIDTH-1];
        for (int k = 1; k < WIDTH; k++) begin
            galois_ns[k] = q_q[k-1] ^ (TAPS[k] & q_q[WIDTH-1]);
        end
        fib_fb = q_q[WIDTH-1] ^ (^(q_q[WIDTH-2:0] & TAPS[WIDTH-2:0]));
        fib_ns = {q_q[WIDTH-2:0], fib_fb};
        ns     = mode ? fib_ns : galois_ns;
    end

    assign seed_zero = (seed == '0);
    assign load_val  = seed_zero ? SEED : seed;

    always_comb begin
        q_d     = q_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        zfix_d  = 1'b0;
        if (load) begin
            q_d     = load_val;
            start_d = load_val;
            cnt_d   = '0;
            zfix_d  = seed_zero;
        end else if (en) begin
            q_d = ns;
            if (ns == start_q) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_q     <= SEED;
            start_q <= SEED;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            zfix_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            zfix_q  <= zfix_d;
        end
    end

    assign q    = q_q;
    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign zfix = zfix_q;

endmodule
